project3_alu_v_top: RTL and testbench
=====================================

Name: project3_alu_v_top

Overview:
- Registered 32-bit RV32I-style execute-stage ALU with a built-in ALU-control decoder.
- Decodes the 2-bit main-control `aluop` and the 10-bit `funccode` = {funct7[6:0], funct3[2:0]} into an operation, then computes the result and the zero, overflow and carry flags.
- Sits between the decode/control stage and memory/branch logic. It serves load/store address add, branch compare subtract and R-type ops.

Parameters:
- WIDTH, 32, datapath width of a, b and result. Flags are taken from bit WIDTH-1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset: synchronous, active-low
- aluop  in  2  0 = load/store (add), 1 = branch (sub), 2 = R-type (decode funccode), 3 = reserved
- funccode  in  10  {funct7, funct3}. Bit 8 is funct7[5], which selects sub/sra. Bits [2:0] are funct3.
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- zero  out  1  registered: result == 0
- result  out  WIDTH  registered ALU result
- overflow  out  1  registered signed overflow (add/sub only)
- carryout  out  1  registered carry out of bit WIDTH-1 (add/sub only)

Behaviour:
- Reset: on a rising clk edge with rst_n=0, outputs become result=0, zero=1, overflow=0, carryout=0. Reset overrides any operation in flight.
- Latency: inputs are sampled at each rising edge with rst_n=1, and outputs update at that same edge (1 cycle). Outputs hold between edges. There is no handshake; a new operation is accepted every cycle.
- Decode by aluop:
  - aluop=0: ADD.
  - aluop=1: SUB.
  - aluop=3: ADD (reserved).
  - aluop=2: decode funct3:
    - 0: ADD, or SUB when funccode[8]=1
    - 1: SLL
    - 2: SLT (signed)
    - 3: SLTU
    - 4: XOR
    - 5: SRL, or SRA when funccode[8]=1
    - 6: OR
    - 7: AND
  - funccode bits 9 and 7:3 are ignored.
  - When aluop is 0, 1 or 3, funccode is ignored entirely.
- Adder:
  - sum = a + (sub ? ~b : b) + sub, computed WIDTH+1 bits wide.
  - carryout = sum[WIDTH]. So SUB with a == b gives carryout=1.
- overflow:
  - ADD: a[31]==b[31] and result[31]!=a[31].
  - SUB: a[31]!=b[31] and result[31]!=a[31].
- All non-add/sub ops force overflow=0 and carryout=0.
- Shifts use b[4:0] as the amount; larger bits of b are ignored. SRA sign-fills.
- SLT/SLTU: result = {31'b0, lt}.
- Wrap-around: results are modulo 2^32. Overflow is reported, never trapped.
- zero is computed from the final result for every op.

Decomposition:
- Shared package `p3_alu_pkg`:
  - aluop encodings: ALUOP_MEM=0, ALUOP_BR=1, ALUOP_R=2.
  - funct3 constants.
  - Internal op enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- One combinational sub-module, `p3_alu_core`: op + a + b -> result/zero/overflow/carryout.
- The top module holds the decoder and the output register.

Test Plan:
- Logic ops: aluop=2, funccode=7, a=7, b=5 -> result=5 after 1 edge. Same operands with funccode=6 -> result=7.
- Mem/branch: aluop=0, a=7, b=5 -> result=0xC. aluop=1, a=7, b=5 -> result=2, zero=0, overflow=0, carryout=1. aluop=1, a=b=1 -> result=0, zero=1, overflow=0, carryout=1.
- R-type add/sub: aluop=2, funccode=0, a=0x17, b=0xD -> 0x24. funccode=256, same operands -> 0xA, overflow=0.
- Overflow:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1, carryout=0.
  - ADD 0xFFFFFFFF+0x80000000 -> 0x7FFFFFFF, overflow=1, carryout=1.
  - ADD 0x80000002+1 -> 0x80000003, overflow=0.
- Zero/wrap: ADD 0xFFFFFFFF+1 -> result=0, zero=1, overflow=0, carryout=1. SUB 0x80000002-1 -> 0x80000001, overflow=0.
- Reset mid-stream: assert rst_n=0 for one edge while aluop=2 -> result=0, zero=1, flags 0. Extended ops: SRA 0x80000000 by 4 -> 0xF8000000; SLT -1 < 1 -> 1; SLTU -> 0.

Source files
------------

// File: rtl/p3_alu_pkg.sv
// Shared encodings for the project3 execute-stage ALU: main-control aluop values,
// funct3 constants and the internal operation enum used between decoder and core.
package p3_alu_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'd0;
  localparam logic [1:0] ALUOP_BR  = 2'd1;
  localparam logic [1:0] ALUOP_R   = 2'd2;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND
  } alu_op_e;

endpackage

// File: rtl/p3_alu_core.sv
// Combinational ALU datapath: executes one decoded operation and derives the
// zero, signed-overflow and carry flags (flags other than zero only for add/sub).
module p3_alu_core
  import p3_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carryout
);

  localparam int SHW = $clog2(WIDTH);

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;

  // Subtraction reuses the adder as a + ~b + 1 so the carry doubles as "no borrow".
  always_comb begin
    is_sub   = (op == OP_SUB);
    is_arith = (op == OP_ADD) || (op == OP_SUB);
    b_eff    = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt    = b[SHW-1:0];

    result   = sum[WIDTH-1:0];
    unique case (op)
      OP_ADD, OP_SUB: result = sum[WIDTH-1:0];
      OP_SLL:         result = a << shamt;
      OP_SLT:         result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:        result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:         result = a ^ b;
      OP_SRL:         result = a >> shamt;
      OP_SRA:         result = $signed(a) >>> shamt;
      OP_OR:          result = a | b;
      OP_AND:         result = a & b;
      default:        result = sum[WIDTH-1:0];
    endcase

    carryout = is_arith & sum[WIDTH];
    overflow = is_arith & (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    zero     = (result == '0);
  end

endmodule

// File: rtl/project3_alu_v_top.sv
// Registered execute-stage ALU: decodes aluop/funccode into an operation, runs it
// through p3_alu_core and captures result and flags on every rising clock edge.
module project3_alu_v_top
  import p3_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       aluop,
  input  logic [9:0]       funccode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             zero,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carryout
);

  alu_op_e          alu_op;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;
  logic             carryout_d, carryout_q;
  logic             unused_funccode;

  assign unused_funccode = ^{funccode[9], funccode[7:3]};

  // Only R-type looks at funccode; reserved aluop falls back to add.
  always_comb begin
    alu_op = OP_ADD;
    case (aluop)
      ALUOP_MEM: alu_op = OP_ADD;
      ALUOP_BR:  alu_op = OP_SUB;
      ALUOP_R: begin
        case (funccode[2:0])
          F3_ADD:  alu_op = funccode[8] ? OP_SUB : OP_ADD;
          F3_SLL:  alu_op = OP_SLL;
          F3_SLT:  alu_op = OP_SLT;
          F3_SLTU: alu_op = OP_SLTU;
          F3_XOR:  alu_op = OP_XOR;
          F3_SR:   alu_op = funccode[8] ? OP_SRA : OP_SRL;
          F3_OR:   alu_op = OP_OR;
          F3_AND:  alu_op = OP_AND;
          default: alu_op = OP_ADD;
        endcase
      end
      default:   alu_op = OP_ADD;
    endcase
  end

  p3_alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (alu_op),
    .a        (a),
    .b        (b),
    .result   (result_d),
    .zero     (zero_d),
    .overflow (overflow_d),
    .carryout (carryout_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      carryout_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      carryout_q <= carryout_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign carryout = carryout_q;

endmodule

// File: tb/tb_project3_alu_v_top.sv
// Self-checking bench for project3_alu_v_top: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_project3_alu_v_top;

  logic        clk;
  logic        rst_n;
  logic [1:0]  aluop;
  logic [9:0]  funccode;
  logic [31:0] a;
  logic [31:0] b;
  logic        zero;
  logic [31:0] result;
  logic        overflow;
  logic        carryout;

  int total;
  int bad;

  project3_alu_v_top #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aluop    (aluop),
    .funccode (funccode),
    .a        (a),
    .b        (b),
    .zero     (zero),
    .result   (result),
    .overflow (overflow),
    .carryout (carryout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {result, zero, overflow, carryout} from plain signed/unsigned arithmetic.
  function automatic logic [34:0] ref_model(input logic [1:0] op, input logic [9:0] fc,
                                            input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        o;
    logic        c;
    logic        sub;
    longint      sx;
    longint      sy;
    longint      s;
    longint      ux;
    longint      uy;
    longint      sh_tmp;
    int          sh;
    r  = 32'd0;
    o  = 1'b0;
    c  = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    sh = int'(y[4:0]);
    if (op != 2'd2 || fc[2:0] == 3'd0) begin
      sub = (op == 2'd1) || (op == 2'd2 && fc[8]);
      if (sub) begin
        s = sx - sy;
        r = x - y;
        c = (x >= y);
      end else begin
        s = sx + sy;
        r = x + y;
        c = (ux + uy) >= 64'h1_0000_0000;
      end
      o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      case (fc[2:0])
        3'd1: r = x << sh;
        3'd2: r = (sx < sy) ? 32'd1 : 32'd0;
        3'd3: r = (x < y) ? 32'd1 : 32'd0;
        3'd4: r = x ^ y;
        3'd5: begin
          sh_tmp = sx >>> sh;
          r = fc[8] ? sh_tmp[31:0] : (x >> sh);
        end
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end
    return {r, (r == 32'd0), o, c};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Drive one operation between edges and let it be captured by the next rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [9:0] fc,
                               input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    aluop    = op;
    funccode = fc;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [34:0] got;
    rst_n = 1'b0;
    applyStimulus(2'd2, 10'h100, 32'h1234_5678, 32'h0000_0003);
    got = {result, zero, overflow, carryout};
    total++;
    if (got !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h want=%h", got, {32'd0, 1'b1, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [15] = '{2, 2, 0, 1, 1, 2, 2, 0, 0, 0, 0, 1, 2, 2, 2};
    logic [9:0]  fcs [15] = '{7, 6, 0, 0, 0, 0, 256, 0, 0, 0, 0, 0, 10'h105, 2, 3};
    logic [31:0] as  [15] = '{7, 7, 7, 7, 1, 32'h17, 32'h17, 32'h7FFFFFFF, 32'hFFFFFFFF,
                              32'h80000002, 32'hFFFFFFFF, 32'h80000002, 32'h80000000,
                              32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [15] = '{5, 5, 5, 5, 1, 32'hD, 32'hD, 1, 32'h80000000, 1, 1, 1, 4, 1, 1};
    logic [34:0] exp [15] = '{{32'h5, 3'b000}, {32'h7, 3'b000}, {32'hC, 3'b000},
                              {32'h2, 3'b001}, {32'h0, 3'b101}, {32'h24, 3'b000},
                              {32'hA, 3'b001}, {32'h80000000, 3'b010},
                              {32'h7FFFFFFF, 3'b011}, {32'h80000003, 3'b000},
                              {32'h0, 3'b101}, {32'h80000001, 3'b001},
                              {32'hF8000000, 3'b000}, {32'h1, 3'b000}, {32'h0, 3'b100}};
    logic [34:0] got;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(ops[i], fcs[i], as[i], bs[i]);
      got = {result, zero, overflow, carryout};
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("[TB] FAIL directed_%0d got=%h want=%h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [9:0]  fc;
    logic [31:0] x;
    logic [31:0] y;
    logic [34:0] exp;
    logic [34:0] got;
    for (int i = 0; i < 400; i++) begin
      op  = 2'($urandom_range(0, 3));
      fc  = 10'($urandom);
      x   = rand_operand();
      y   = rand_operand();
      exp = ref_model(op, fc, x, y);
      applyStimulus(op, fc, x, y);
      got = {result, zero, overflow, carryout};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL random_%0d op=%0d fc=%h a=%h b=%h got=%h want=%h",
                 i, op, fc, x, y, got, exp);
      end
    end
  endtask

  // Outputs must hold while new inputs wait for the next edge.
  task automatic test_back_to_back();
    logic [34:0] exp_prev;
    logic [34:0] exp_next;
    logic [34:0] got;
    exp_prev = ref_model(2'd2, 10'h004, 32'hA5A5_0F0F, 32'h0FF0_1234);
    applyStimulus(2'd2, 10'h004, 32'hA5A5_0F0F, 32'h0FF0_1234);
    @(negedge clk);
    aluop    = 2'd2;
    funccode = 10'h001;
    a        = 32'h0000_0001;
    b        = 32'hFFFF_FFFF;
    exp_next = ref_model(2'd2, 10'h001, 32'h0000_0001, 32'hFFFF_FFFF);
    #2;
    got = {result, zero, overflow, carryout};
    total++;
    if (got !== exp_prev) begin
      bad++;
      $display("[TB] FAIL hold_between_edges got=%h want=%h", got, exp_prev);
    end
    @(posedge clk);
    #1;
    got = {result, zero, overflow, carryout};
    total++;
    if (got !== exp_next) begin
      bad++;
      $display("[TB] FAIL back_to_back got=%h want=%h", got, exp_next);
    end
  endtask

  task automatic test_reset_midstream();
    logic [34:0] got;
    logic [34:0] exp;
    applyStimulus(2'd0, 10'h000, 32'h0000_0003, 32'h0000_0004);
    rst_n = 1'b0;
    applyStimulus(2'd2, 10'h006, 32'hFFFF_0000, 32'h0000_FFFF);
    got = {result, zero, overflow, carryout};
    total++;
    if (got !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_midstream got=%h want=%h", got, {32'd0, 1'b1, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    exp = ref_model(2'd2, 10'h006, 32'hFFFF_0000, 32'h0000_FFFF);
    applyStimulus(2'd2, 10'h006, 32'hFFFF_0000, 32'h0000_FFFF);
    got = {result, zero, overflow, carryout};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL after_reset_release got=%h want=%h", got, exp);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    aluop    = 2'd0;
    funccode = 10'd0;
    a        = 32'd0;
    b        = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
